// File: rtl/mux_21_arb.sv
// mux_21_arb: round-robin select controller and output register for a 2:1 mux.
// Two request lines compete for the mux select. Each grant lasts at most HOLD
// consecutive cycles when the other channel is waiting. The selected data bit
// is registered as y, and vld marks the cycles on which y holds a sampled bit.
module mux_21_arb #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] I,
  output logic       s,
  output logic [1:0] gnt,
  output logic       y,
  output logic       vld
);

  localparam int            CW         = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic          last;      // channel most recently granted
  logic [CW-1:0] cnt;       // grant cycles left in the current burst, minus one

  logic grant_en;           // (re)grant grant_ch on this edge
  logic grant_ch;
  logic hold_en;            // keep the current grant and consume one burst cycle
  logic release_en;         // nobody wants the mux any more: drop back to idle

  // Arbitration decision taken from the sampled requests and current grant.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    grant_en   = 1'b0;
    grant_ch   = s;
    hold_en    = 1'b0;
    release_en = 1'b0;
    if (state == IDLE) begin
      if (req != 2'b00) begin
        grant_en = 1'b1;
        // On a tie the channel not served last wins.
        grant_ch = (req == 2'b11) ? ~last : req[1];
      end
    end else begin
      if (req[s] && (cnt != '0)) begin
        hold_en = 1'b1;
      end else if (req[~s]) begin
        grant_en = 1'b1;
        grant_ch = ~s;
      end else if (req[s]) begin
        grant_en = 1'b1;
        grant_ch = s;
      end else begin
        release_en = 1'b1;
      end
    end
  end

  // Grant state: select, one-hot grant, burst counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state <= IDLE;
      s     <= 1'b0;
      gnt   <= 2'b00;
      cnt   <= '0;
      last  <= 1'b1;
    end else if (grant_en) begin
      state <= BUSY;
      s     <= grant_ch;
      gnt   <= grant_ch ? 2'b10 : 2'b01;
      cnt   <= CNT_RELOAD;
      last  <= grant_ch;
    end else if (hold_en) begin
      cnt <= cnt - CW'(1);
    end else if (release_en) begin
      // s is left on the channel just released.
      state <= IDLE;
      gnt   <= 2'b00;
    end
  end

  // Output register: captures the mux output while a grant is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y   <= 1'b0;
      vld <= 1'b0;
    end else begin
      if (state == BUSY) begin
        y <= I[s];
      end
      vld <= (state == BUSY);
    end
  end

endmodule

// File: tb/tb_mux_21_arb.sv
// Testbench for mux_21_arb: two instances (HOLD=4 and HOLD=1) share the same
// stimulus and are compared every cycle against a burst-counting owner model.
module tb_mux_21_arb;

  localparam int HOLD_V [2] = '{4, 1};

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] din;
  logic [1:0] s_o;
  logic [1:0] gnt_o [2];
  logic [1:0] y_o;
  logic [1:0] vld_o;

  int errors;
  int checks;
  bit cmp_en;

  // Reference model: owner (-1 = nobody), grant cycles used in the burst.
  int m_own  [2];
  int m_used [2];
  int m_sel  [2];
  int m_last [2];
  int m_y    [2];
  int m_vld  [2];

  mux_21_arb #(.HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .I(din),
    .s(s_o[0]), .gnt(gnt_o[0]), .y(y_o[0]), .vld(vld_o[0])
  );

  mux_21_arb #(.HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .I(din),
    .s(s_o[1]), .gnt(gnt_o[1]), .y(y_o[1]), .vld(vld_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_used[k] = 0;
      m_sel[k]  = 0;
      m_last[k] = 1;
      m_y[k]    = 0;
      m_vld[k]  = 0;
    end
  endtask

  task automatic model_start(input int k, input int ch);
    m_own[k]  = ch;
    m_sel[k]  = ch;
    m_last[k] = ch;
    m_used[k] = 1;
  endtask

  // One rising edge of the model, using the requests/data sampled at that edge.
  task automatic model_step();
    int c;
    for (int k = 0; k < 2; k++) begin
      if (m_own[k] >= 0) begin
        m_y[k]   = int'(din[m_sel[k]]);
        m_vld[k] = 1;
      end else begin
        m_vld[k] = 0;
      end
      if (m_own[k] < 0) begin
        if (req == 2'b11)      model_start(k, 1 - m_last[k]);
        else if (req == 2'b01) model_start(k, 0);
        else if (req == 2'b10) model_start(k, 1);
      end else begin
        c = m_own[k];
        if (req[c] && m_used[k] < HOLD_V[k]) m_used[k]++;
        else if (req[1-c])                   model_start(k, 1 - c);
        else if (req[c])                     model_start(k, c);
        else                                 m_own[k] = -1;
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, then advance the model at the rising edge.
  task automatic step(input logic [1:0] r, input logic [1:0] d);
    @(negedge clk);
    rst = 1'b0;
    req = r;
    din = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare process: every falling edge, all outputs of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("cmp h%0d s", HOLD_V[k]),   32'(s_o[k]),   32'(m_sel[k]));
        check($sformatf("cmp h%0d gnt", HOLD_V[k]), 32'(gnt_o[k]),
              (m_own[k] < 0) ? 32'd0 : (32'd1 << m_own[k]));
        check($sformatf("cmp h%0d y", HOLD_V[k]),   32'(y_o[k]),   32'(m_y[k]));
        check($sformatf("cmp h%0d vld", HOLD_V[k]), 32'(vld_o[k]), 32'(m_vld[k]));
      end
    end
  end

  logic [1:0] pat4 [12];

  initial begin
    errors = 0;
    checks = 0;
    cmp_en = 1'b0;
    rst    = 1'b1;
    req    = 2'b00;
    din    = 2'b00;
    model_reset();
    #1;
    check("reset s", 32'(s_o[0]), 32'd0);
    check("reset gnt", 32'(gnt_o[0]), 32'd0);
    check("reset vld", 32'(vld_o[0]), 32'd0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester on HOLD=4: grant after one edge, data after two, no drop.
    step(2'b01, 2'b01);
    check("single gnt edge1", 32'(gnt_o[0]), 32'h1);
    check("single vld edge1", 32'(vld_o[0]), 32'd0);
    step(2'b01, 2'b01);
    check("single y edge2", 32'(y_o[0]), 32'd1);
    check("single vld edge2", 32'(vld_o[0]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(2'b01, 2'b01);
      check("single gnt held", 32'(gnt_o[0]), 32'h1);
    end
    step(2'b00, 2'b01);
    check("release gnt", 32'(gnt_o[0]), 32'h0);
    check("release vld still", 32'(vld_o[0]), 32'd1);
    step(2'b00, 2'b01);
    check("release vld low", 32'(vld_o[0]), 32'd0);

    // Asynchronous reset in the middle of a channel-1 burst.
    step(2'b10, 2'b10);
    step(2'b10, 2'b10);
    check("pre-reset y", 32'(y_o[0]), 32'd1);
    check("pre-reset s", 32'(s_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst s", 32'(s_o[0]), 32'd0);
    check("async rst gnt", 32'(gnt_o[0]), 32'h0);
    check("async rst y", 32'(y_o[0]), 32'd0);
    check("async rst vld", 32'(vld_o[0]), 32'd0);
    model_reset();
    step(2'b00, 2'b10);

    // Contention with I=10: HOLD=4 bursts of four, HOLD=1 alternates every cycle.
    pat4 = '{2'h1, 2'h1, 2'h1, 2'h1, 2'h2, 2'h2, 2'h2, 2'h2, 2'h1, 2'h1, 2'h1, 2'h1};
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 2'b10);
      check("burst gnt h4", 32'(gnt_o[0]), 32'(pat4[i]));
      check("toggle s h1", 32'(s_o[1]), 32'(i % 2));
      if (i > 0) begin
        check("burst y h4", 32'(y_o[0]), (pat4[i-1] == 2'h2) ? 32'd1 : 32'd0);
        check("burst vld h4", 32'(vld_o[0]), 32'd1);
        check("toggle y h1", 32'(y_o[1]), 32'((i - 1) % 2));
      end
    end

    // Early drop: channel 0 loses its request mid-burst, grant moves at once.
    step(2'b01, 2'b10);
    check("early gnt0 a", 32'(gnt_o[0]), 32'h1);
    step(2'b11, 2'b10);
    check("early gnt0 b", 32'(gnt_o[0]), 32'h1);
    step(2'b10, 2'b10);
    check("early switch", 32'(gnt_o[0]), 32'h2);

    // Idle after channel 1, then a tie: channel 0 wins, s parks on 1 while idle.
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 2'b01);
      check("idle gnt", 32'(gnt_o[0]), 32'h0);
      check("idle s", 32'(s_o[0]), 32'd1);
    end
    step(2'b11, 2'b01);
    check("tie gnt", 32'(gnt_o[0]), 32'h1);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r = 2'b00;
      step(r, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        model_reset();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_21_arb.md
# mux_21_arb

Round-robin select controller and output register placed directly upstream of the 2:1 select mux. It arbitrates between two single-bit sources I[0]/I[1] with request lines, drives the mux select s, and holds each grant for a bounded burst. It registers the selected bit as y with a valid flag for the downstream consumer.

## Interface

Parameters:
- HOLD, default 4: maximum consecutive grant cycles per channel burst; legal range 1..255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req, input, 2: per-channel request; req[k] high means channel k has data on I[k].
- I, input, 2: data bits; I[0] is channel 0, I[1] is channel 1.
- s, output, 1: registered mux select; 0 selects I[0], 1 selects I[1].
- gnt, output, 2: registered one-hot grant; 00 when idle; gnt[s] is the only bit that can be high.
- y, output, 1: registered selected data bit.
- vld, output, 1: y holds a bit sampled under a grant.

## Operation

- State: IDLE / BUSY. Internal regs: last (channel most recently granted), cnt (width clog2(HOLD+1)).
- Reset values: state=IDLE, s=0, gnt=00, y=0, vld=0, cnt=0, last=1. With last=1, channel 0 wins the first tie.
- IDLE:
  - req=00: stay; s holds its value; gnt=00.
  - Exactly one req bit high: grant that channel.
  - req=11: grant ~last.
  - On a grant: s<=k, gnt<=onehot(k), cnt<=HOLD-1, last<=k, state<=BUSY.
- BUSY, current channel c=s, evaluated each edge:
  - req[c]=1 and cnt!=0: stay; cnt<=cnt-1.
  - Otherwise (burst exhausted or request dropped):
    - If req[~c]=1: switch to ~c in the same edge with no idle cycle; cnt reloaded to HOLD-1; last<=~c.
    - Else if req[c]=1 (cnt==0, no competitor): re-grant c; cnt reloaded.
    - Else: state<=IDLE, gnt<=00; s keeps c.
- Data path, every edge:
  - y <= (state==BUSY) ? I[s] : y.
  - vld <= (state==BUSY).
  - y is sampled with the s/state values present before the edge.
- A request dropping mid-burst ends the burst at that edge. The channel is never granted on a cycle where its req was seen low.
- Arithmetic: cnt only decrements while nonzero; no wrap. HOLD=1 gives cnt=0 always, so channels alternate every cycle when both request.

## Timing

- Grant latency: req rising in IDLE -> s/gnt valid after 1 edge.
- Data latency: y/vld appear 1 edge after the grant edge, so 2 edges after req.
- Burst length:
  - With req held: exactly HOLD grant cycles before a switch, when the other channel requests.
  - With no contender: continuous re-grant, gnt never drops.
- Switchover: gnt moves 01 -> 10 in one edge; vld stays high across the switch.
- Release: gnt=00 one edge after req[c] is sampled low; vld falls one edge later.
- rst asserted mid-burst: all outputs go to reset values immediately, without a clock. After release, arbitration restarts from IDLE with last=1.
- Simultaneous req change and burst end at the same edge: the rules above are evaluated on the sampled req values; there is no priority beyond round-robin.

## Test plan

- Reset mid-burst:
  - Stimulus: assert rst asynchronously during a BUSY burst.
  - Required: s=0, gnt=00, y=0, vld=0 before the next edge.
  - Then: with req=11 after release, gnt=01 first.
- Single requester, HOLD=4:
  - Stimulus: req=01, I=2'b01.
  - Required: gnt=01 after edge 1; y=1 and vld=1 from edge 2; gnt stays 01 indefinitely.
  - Then: drop req -> gnt=00 next edge, vld=0 the edge after.
- Both requesting, HOLD=4, I=2'b10:
  - Required: gnt pattern 01×4, 10×4, 01×4; y follows 0×4, 1×4 one edge late; vld continuously 1.
- HOLD=1, req=11, I=2'b10:
  - Required: s toggles every cycle; y toggles 0,1,0,1 delayed one edge.
- Early drop:
  - Stimulus: req=11, channel 0 granted; drop req[0] after 2 cycles.
  - Required: grant switches to 10 at that edge, not after 4 cycles.
- Idle-to-contention tie:
  - Stimulus: channel 1 last served, then req=00 for 3 cycles, then req=11.
  - Required: gnt=01 is granted first; s holds 1 throughout idle.
